// File: rtl/lc3b_types.sv
// Shared LC-3b datapath encodings: PC mux select and fetch FSM state codes.
package lc3b_types;

  typedef enum logic [1:0] {
    PCSEL_BUS   = 2'b00,
    PCSEL_INC   = 2'b01,
    PCSEL_ADDER = 2'b10,
    PCSEL_ZERO  = 2'b11
  } pc_sel_t;

  // Values double as the state_dbg LED code.
  typedef enum logic [3:0] {
    ST_HALTED = 4'd0,
    ST_S18    = 4'd1,
    ST_S33    = 4'd2,
    ST_S35    = 4'd3,
    ST_PAUSE1 = 4'd4,
    ST_PAUSE2 = 4'd5
  } fetch_state_t;

  localparam int WAIT_W = 3;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter with a zero flag; times the SRAM read hold in S33.
module wait_counter #(
  parameter int W = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// LC-3b instruction fetch sequencer: MAR<-PC/PC<-PC+1, SRAM read into MDR, IR<-MDR.
// Optional single-step pause after each IR load, released by a Continue press/release.
//
// state   | meaning
// HALTED  | idle, waiting for Run
// S18     | MAR<-PC, PC<-PC+1 (GatePC)
// S33     | SRAM read held MEM_WAIT cycles, MDR loads in the last one
// S35     | IR<-MDR (GateMDR), fetch counted
// PAUSE1  | single-step: waiting for Continue press
// PAUSE2  | single-step: waiting for Continue release
module fetch_ctrl
  import lc3b_types::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Continue,
  input  logic             step_mode,
  output logic             load_mar,
  output logic             load_pc,
  output logic             load_mdr,
  output logic             load_ir,
  output logic [1:0]       pc_sel,
  output logic             GatePC,
  output logic             GateMDR,
  output logic             mem_ce_n,
  output logic             mem_oe_n,
  output logic             mem_we_n,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t state, state_nxt;
  logic         wait_zero;

  wait_counter #(.W(WAIT_W)) u_wait (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (state == ST_S18),
    .dec      (state == ST_S33),
    .load_val (WAIT_W'(MEM_WAIT - 1)),
    .zero     (wait_zero)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_HALTED;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                fetch_count <= '0;
    else if (state == ST_S35) fetch_count <= fetch_count + 1'b1;
  end

  always_comb begin
    state_nxt = ST_HALTED;
    case (state)
      ST_HALTED: state_nxt = Run ? ST_S18 : ST_HALTED;
      ST_S18:    state_nxt = ST_S33;
      ST_S33:    state_nxt = wait_zero ? ST_S35 : ST_S33;
      ST_S35:    state_nxt = step_mode ? ST_PAUSE1 : ST_S18;
      ST_PAUSE1: state_nxt = Continue ? ST_PAUSE2 : ST_PAUSE1;
      ST_PAUSE2: state_nxt = Continue ? ST_PAUSE2 : ST_S18;
      default:   state_nxt = ST_HALTED;
    endcase
  end

  // Moore decode: every strobe depends on state alone (load_mdr via the counter's flag).
  always_comb begin
    load_mar = 1'b0;
    load_pc  = 1'b0;
    load_mdr = 1'b0;
    load_ir  = 1'b0;
    pc_sel   = PCSEL_INC;
    GatePC   = 1'b0;
    GateMDR  = 1'b0;
    mem_ce_n = 1'b1;
    mem_oe_n = 1'b1;
    mem_we_n = 1'b1;
    case (state)
      ST_S18: begin
        GatePC   = 1'b1;
        load_mar = 1'b1;
        load_pc  = 1'b1;
      end
      ST_S33: begin
        mem_ce_n = 1'b0;
        mem_oe_n = 1'b0;
        load_mdr = wait_zero;
      end
      ST_S35: begin
        GateMDR = 1'b1;
        load_ir = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: two builds (MEM_WAIT=2/CNT_W=16 and MEM_WAIT=7/CNT_W=4)
// share stimulus and are compared every cycle against a fetch-progress reference model.
module tb_fetch_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  logic Continue = 1'b0;
  logic step_mode = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic        load_mar_a, load_pc_a, load_mdr_a, load_ir_a, gpc_a, gmdr_a, ce_a, oe_a, we_a;
  logic [1:0]  pc_sel_a;
  logic [3:0]  state_a;
  logic [15:0] count_a;
  logic        load_mar_b, load_pc_b, load_mdr_b, load_ir_b, gpc_b, gmdr_b, ce_b, oe_b, we_b;
  logic [1:0]  pc_sel_b;
  logic [3:0]  state_b;
  logic [3:0]  count_b;

  fetch_ctrl #(.MEM_WAIT(2), .CNT_W(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .step_mode(step_mode),
    .load_mar(load_mar_a), .load_pc(load_pc_a), .load_mdr(load_mdr_a), .load_ir(load_ir_a),
    .pc_sel(pc_sel_a), .GatePC(gpc_a), .GateMDR(gmdr_a),
    .mem_ce_n(ce_a), .mem_oe_n(oe_a), .mem_we_n(we_a),
    .state_dbg(state_a), .fetch_count(count_a)
  );

  fetch_ctrl #(.MEM_WAIT(7), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .step_mode(step_mode),
    .load_mar(load_mar_b), .load_pc(load_pc_b), .load_mdr(load_mdr_b), .load_ir(load_ir_b),
    .pc_sel(pc_sel_b), .GatePC(gpc_b), .GateMDR(gmdr_b),
    .mem_ce_n(ce_b), .mem_oe_n(oe_b), .mem_we_n(we_b),
    .state_dbg(state_b), .fetch_count(count_b)
  );

  always #5 Clk = ~Clk;

  logic [10:0] vec_a, vec_b;
  assign vec_a = {load_mar_a, load_pc_a, load_mdr_a, load_ir_a, pc_sel_a, gpc_a, gmdr_a, ce_a, oe_a, we_a};
  assign vec_b = {load_mar_b, load_pc_b, load_mdr_b, load_ir_b, pc_sel_b, gpc_b, gmdr_b, ce_b, oe_b, we_b};

  // Reference model: mode 0 halted, 1 fetching, 2 waiting press, 3 waiting release.
  // pos counts cycles into the current fetch: 0 = address, 1..mw = read, mw+1 = IR load.
  int mw [2] = '{2, 7};
  int cmask [2] = '{32'hFFFF, 32'hF};
  int mode [2] = '{0, 0};
  int pos [2] = '{0, 0};
  int fetches [2] = '{0, 0};

  always @(posedge Clk or posedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        mode[i] = 0; pos[i] = 0; fetches[i] = 0;
      end else begin
        case (mode[i])
          0: if (Run) begin mode[i] = 1; pos[i] = 0; end
          1: if (pos[i] <= mw[i]) pos[i] = pos[i] + 1;
             else begin
               fetches[i] = fetches[i] + 1;
               if (step_mode) mode[i] = 2; else pos[i] = 0;
             end
          2: if (Continue) mode[i] = 3;
          default: if (!Continue) begin mode[i] = 1; pos[i] = 0; end
        endcase
      end
    end
  end

  function automatic logic [3:0] exp_state(int i);
    if (mode[i] == 0) return 4'd0;
    if (mode[i] == 2) return 4'd4;
    if (mode[i] == 3) return 4'd5;
    if (pos[i] == 0) return 4'd1;
    if (pos[i] <= mw[i]) return 4'd2;
    return 4'd3;
  endfunction

  // {load_mar,load_pc,load_mdr,load_ir,pc_sel,GatePC,GateMDR,ce_n,oe_n,we_n}
  function automatic logic [10:0] exp_vec(int i);
    logic [10:0] v;
    v = {4'b0000, 2'b01, 2'b00, 3'b111};
    if (mode[i] == 1) begin
      if (pos[i] == 0)
        v = {4'b1100, 2'b01, 2'b10, 3'b111};
      else if (pos[i] <= mw[i])
        v = {2'b00, (pos[i] == mw[i]), 1'b0, 2'b01, 2'b00, 3'b001};
      else
        v = {4'b0001, 2'b01, 2'b01, 3'b111};
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    check("a.state", 32'(state_a), 32'(exp_state(0)));
    check("a.count", 32'(count_a), fetches[0] & cmask[0]);
    check("a.strobes", 32'(vec_a), 32'(exp_vec(0)));
    check("a.one_driver", 32'(gpc_a & gmdr_a), 32'd0);
    check("b.state", 32'(state_b), 32'(exp_state(1)));
    check("b.count", 32'(count_b), fetches[1] & cmask[1]);
    check("b.strobes", 32'(vec_b), 32'(exp_vec(1)));
    check("b.one_driver", 32'(gpc_b & gmdr_b), 32'd0);
  endtask

  initial begin
    bit found;
    repeat (3) tick();
    Reset = 1'b0;
    repeat (10) tick();

    // Free-run: b needs 16+ fetches of 9 cycles to wrap its 4-bit count.
    Run = 1'b1;
    tick();
    Run = 1'b0;
    repeat (200) tick();

    // Single-step with random Continue presses; Run is noise here.
    step_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if ($urandom_range(0, 3) == 0) Continue = ~Continue;
      Run = 1'($urandom);
    end

    // Release any pause, then hit Reset between edges while dut_a is in its read.
    step_mode = 1'b0;
    Run = 1'b0;
    Continue = 1'b1;
    repeat (2) tick();
    Continue = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (state_a == 4'd2) found = 1'b1;
    end
    check("wait_s33", 32'(found), 32'd1);
    #1 Reset = 1'b1;
    #1;
    check("async.oe_n", 32'(oe_a), 32'd1);
    check("async.state", 32'(state_a), 32'd0);
    check("async.load_mdr", 32'(load_mdr_a), 32'd0);
    check("async.count_a", 32'(count_a), 32'd0);
    check("async.count_b", 32'(count_b), 32'd0);
    tick();
    Reset = 1'b0;
    tick();

    // Everything random, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      tick();
      Run = ($urandom_range(0, 7) == 0);
      step_mode = 1'($urandom);
      if ($urandom_range(0, 2) == 0) Continue = ~Continue;
      Reset = ($urandom_range(0, 63) == 0);
    end
    Reset = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Moore FSM that sequences the LC-3b fetch datapath: MAR<-PC with PC<-PC+1, then a memory read into MDR, then IR<-MDR.
- Drives every load, gate and pc_sel strobe of the datapath, plus the SRAM control strobes.
- Supports a single-step pause after each fetch, released by a Continue press/release handshake.
- Decode/execute states are out of scope; after IR load the FSM returns to fetch.

Parameters:
MEM_WAIT, 2, number of cycles the SRAM read is held (mem_oe_n low) before MDR load; legal 1..7
CNT_W, 16, width of fetch_count

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high; clears all state immediately
Run  input  1  start request (debounced level); sampled only in HALTED
Continue  input  1  single-step release (debounced level)
step_mode  input  1  1 = pause after every IR load; 0 = free-run
load_mar  output  1  MAR load strobe
load_pc  output  1  PC load strobe
load_mdr  output  1  MDR load strobe
load_ir  output  1  IR load strobe
pc_sel  output  2  PC mux select (package constants)
GatePC  output  1  PC onto bus
GateMDR  output  1  MDR onto bus
mem_ce_n  output  1  SRAM chip enable, active-low
mem_oe_n  output  1  SRAM output enable, active-low
mem_we_n  output  1  SRAM write enable, active-low; held 1 (no writes in this block)
state_dbg  output  4  encoded current state for LEDs/bench
fetch_count  output  CNT_W  number of completed IR loads, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock (Clk). Reset is asynchronous and active-high: on assertion, state=HALTED, wait counter=0 and fetch_count=0 immediately, regardless of the clock. This holds mid-fetch too; no partial strobe survives past Reset assertion.
- Outputs are a pure function of state (Moore). Only fetch_count is a register.
- Reset and HALTED output values: all load_* = 0, GatePC = 0, GateMDR = 0, pc_sel = PCSEL_INC, mem_ce_n = 1, mem_oe_n = 1, mem_we_n = 1.
- States and transitions:
  - HALTED: Run=1 -> S18; otherwise stay.
  - S18, 1 cycle: GatePC=1, load_mar=1, load_pc=1, pc_sel=PCSEL_INC. MAR captures the old PC while PC captures PC+1 at the same edge. Next state S33; wait counter loads MEM_WAIT-1.
  - S33, MEM_WAIT cycles: mem_ce_n=0, mem_oe_n=0, no gates asserted (memory drives the bus). The counter decrements each cycle. load_mdr=1 only in the cycle where the counter==0; that cycle exits to S35.
  - S35, 1 cycle: GateMDR=1, load_ir=1, mem_ce_n=1. fetch_count increments at the exiting edge. Next state: step_mode=1 -> PAUSE1, else S18.
  - PAUSE1: Continue=1 -> PAUSE2; otherwise stay. All strobes idle.
  - PAUSE2: Continue=0 -> S18; otherwise stay. One button hold therefore yields exactly one fetch.
- Exactly one bus driver per cycle; GatePC and GateMDR are never both 1. No load is asserted outside the states listed.
- Run is ignored outside HALTED. Continue is ignored outside the PAUSE states. step_mode is sampled only at S35 exit.
- Fetch latency from S18 entry to IR load: 2+MEM_WAIT cycles.
- fetch_count wraps from 2^CNT_W-1 to 0 with no flag.
- state_dbg codes: HALTED=0, S18=1, S33=2, S35=3, PAUSE1=4, PAUSE2=5. Unused encodings recover to HALTED on the next edge.

Decomposition:
- lc3b_types package holds:
  - pc_sel_t (2-bit enum): PCSEL_BUS=2'b00, PCSEL_INC=2'b01, PCSEL_ADDER=2'b10, PCSEL_ZERO=2'b11. This is the same encoding the datapath mux uses.
  - fetch_state_t enum using the state_dbg codes above.
- One natural sub-module, wait_counter: a loadable down-counter with zero flag, sized for MEM_WAIT.
- The output decode stays inline as a single combinational case on state.

Test Plan:
1. Reset=1 then 0, Run=0 for 10 cycles -> state_dbg=0, all strobes idle, mem_*_n=1, fetch_count=0.
2. MEM_WAIT=2, step_mode=0, Run pulsed 1 cycle -> state sequence 1,2,2,3,1,2,2,3...; load_mdr high only on the 2nd S33 cycle; fetch_count=3 after 12 cycles from S18 entry.
3. step_mode=1, Run -> after S35 the FSM holds state_dbg=4. Continue=1 for 5 cycles -> 5. Continue=0 -> exactly one more fetch, then 4 again; fetch_count increments by exactly 1.
4. Reset asserted asynchronously in the middle of S33 (between edges) -> mem_oe_n=1, state_dbg=0 and load_mdr=0 before the next edge; fetch_count=0.
5. MEM_WAIT=1 and MEM_WAIT=7 builds -> S33 lasts 1 and 7 cycles respectively, with load_mdr in its final cycle.
6. CNT_W=4, free-run for 16 fetches -> fetch_count goes 15 -> 0. Throughout, GatePC&GateMDR==0 and mem_we_n==1 every cycle (assertions).
